// File: rtl/beam_sweep_ctrl.sv
// Two-mic delay-and-compare sequencer: captures one 3*WINDOW frame, then sweeps one shared
// |L-R| accumulator over every lag and reports the lag with the smallest SAD.
module beam_sweep_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 30,
    parameter int LAGS       = 60,
    parameter int ACC_WIDTH  = 22
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trigger,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] left_data_in,
    input  logic [DATA_WIDTH-1:0] right_data_in,
    output logic                  busy,
    output logic                  result_valid,
    output logic [5:0]            best_lag,
    output logic [ACC_WIDTH-1:0]  min_sad,
    output logic [1:0]            o_dbg_state
);

    localparam int FRAME = 3 * WINDOW;
    localparam int K_W   = $clog2(FRAME);
    localparam int S_W   = $clog2(LAGS);
    localparam int J_W   = $clog2(WINDOW);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SWEEP   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_right [FRAME];
    logic [DATA_WIDTH-1:0] r_left  [WINDOW];
    logic [K_W-1:0]        r_k;
    logic [S_W-1:0]        r_s;
    logic [J_W-1:0]        r_j;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [ACC_WIDTH-1:0]  r_min;
    logic [5:0]            r_lag_best;

    logic [K_W-1:0]             w_r_idx;
    logic signed [DATA_WIDTH:0] w_l_ext;
    logic signed [DATA_WIDTH:0] w_r_ext;
    logic signed [DATA_WIDTH:0] w_diff;
    logic [DATA_WIDTH:0]        w_term;
    logic [ACC_WIDTH:0]         w_add;
    logic [ACC_WIDTH-1:0]       w_sum;

    assign o_dbg_state = r_state;

    // One term per clock: the same subtractor/adder serves every lag position.
    always_comb begin
        w_r_idx = K_W'(r_j) + K_W'(r_s);
        w_l_ext = {r_left[r_j][DATA_WIDTH-1], r_left[r_j]};
        w_r_ext = {r_right[w_r_idx][DATA_WIDTH-1], r_right[w_r_idx]};
        w_diff  = w_l_ext - w_r_ext;
        w_term  = w_diff[DATA_WIDTH] ? (DATA_WIDTH+1)'(-w_diff) : (DATA_WIDTH+1)'(w_diff);
        w_add   = {1'b0, r_acc} + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, w_term};
        if (r_j == '0)
            w_sum = {{(ACC_WIDTH-DATA_WIDTH-1){1'b0}}, w_term};
        else if (w_add[ACC_WIDTH])
            w_sum = '1;
        else
            w_sum = w_add[ACC_WIDTH-1:0];
    end

    // Sample buffers are intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE && sample_valid) begin
            r_right[r_k] <= right_data_in;
            if (r_k >= K_W'(WINDOW) && r_k < K_W'(2 * WINDOW))
                r_left[J_W'(r_k - K_W'(WINDOW))] <= left_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            best_lag     <= '0;
            min_sad      <= '0;
            r_k          <= '0;
            r_s          <= '0;
            r_j          <= '0;
            r_acc        <= '0;
            r_min        <= '1;
            r_lag_best   <= '0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_state    <= S_CAPTURE;
                        busy       <= 1'b1;
                        r_k        <= '0;
                        r_min      <= '1;
                        r_lag_best <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (sample_valid) begin
                        if (r_k == K_W'(FRAME - 1)) begin
                            r_k     <= '0;
                            r_s     <= '0;
                            r_j     <= '0;
                            r_state <= S_SWEEP;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                S_SWEEP: begin
                    r_acc <= w_sum;
                    if (r_j == J_W'(WINDOW - 1)) begin
                        r_j <= '0;
                        // Strict compare: on a tie the smaller lag wins.
                        if (w_sum < r_min) begin
                            r_min      <= w_sum;
                            r_lag_best <= 6'(r_s);
                        end
                        if (r_s == S_W'(LAGS - 1)) begin
                            r_s     <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                S_DONE: begin
                    best_lag     <= r_lag_best;
                    min_sad      <= r_min;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_sweep_ctrl.sv
// Directed bench for beam_sweep_ctrl: frames are driven from per-test sample tables and
// the expected lag/SAD/latency of each frame is queued and checked at result_valid.
module tb_beam_sweep_ctrl;

    localparam int DW       = 16;
    localparam int W        = 30;
    localparam int L        = 60;
    localparam int AW       = 22;
    localparam int FRAME    = 3 * W;
    localparam int BASE_LAT = 1892;
    localparam int GAP_LEN  = 3;

    logic          clk;
    logic          reset_n;
    logic          trigger;
    logic          sample_valid;
    logic [DW-1:0] left_data_in;
    logic [DW-1:0] right_data_in;
    logic          busy;
    logic          result_valid;
    logic [5:0]    best_lag;
    logic [AW-1:0] min_sad;
    logic [1:0]    o_dbg_state;

    beam_sweep_ctrl #(.DATA_WIDTH(DW), .WINDOW(W), .LAGS(L), .ACC_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .trigger      (trigger),
        .sample_valid (sample_valid),
        .left_data_in (left_data_in),
        .right_data_in(right_data_in),
        .busy         (busy),
        .result_valid (result_valid),
        .best_lag     (best_lag),
        .min_sad      (min_sad),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [AW+5:0] exp_q[$];
    int            lat_q[$];
    logic [DW-1:0] left_mem  [FRAME];
    logic [DW-1:0] right_mem [FRAME];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Modes: 1 ramp, 2 right delayed by 5, 3 constant, 4 full-scale opposite, 5 random.
    function automatic void fill(input int mode);
        for (int k = 0; k < FRAME; k++) begin
            case (mode)
                1: begin left_mem[k] = DW'(100 * k); right_mem[k] = DW'(100 * k); end
                2: begin
                    left_mem[k]  = DW'(100 * k);
                    right_mem[k] = (k < 5) ? '0 : DW'(100 * (k - 5));
                end
                3: begin left_mem[k] = 16'h1234; right_mem[k] = 16'h1234; end
                4: begin left_mem[k] = 16'h7FFF; right_mem[k] = 16'h8000; end
                default: begin
                    left_mem[k]  = DW'($urandom_range(0, 65535));
                    right_mem[k] = DW'($urandom_range(0, 65535));
                end
            endcase
        end
    endfunction

    // Reference SAD sweep straight from the frame tables.
    function automatic void model_push(input int lat);
        longint best_sad = (64'd1 << AW) - 1;
        int     best     = 0;
        for (int s = 0; s < L; s++) begin
            longint sad = 0;
            for (int j = 0; j < W; j++) begin
                int d;
                d = int'($signed(left_mem[W + j])) - int'($signed(right_mem[j + s]));
                sad += (d < 0) ? -d : d;
            end
            if (sad > (64'd1 << AW) - 1) sad = (64'd1 << AW) - 1;
            if (sad < best_sad) begin best_sad = sad; best = s; end
        end
        exp_q.push_back({6'(best), AW'(best_sad)});
        lat_q.push_back(lat);
    endfunction

    // driver tasks
    task automatic drive_frame(input bit gaps, input bit noisy);
        trigger = 1'b1;
        @(posedge clk); #1; cyc = 1;
        trigger = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            if (gaps && (k % 10 == 5)) begin
                sample_valid = 1'b0;
                repeat (GAP_LEN) begin @(posedge clk); #1; cyc++; end
            end
            left_data_in  = left_mem[k];
            right_data_in = right_mem[k];
            sample_valid  = 1'b1;
            trigger       = noisy && (k == 40);
            @(posedge clk); #1; cyc++;
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
    endtask

    task automatic wait_result(input bit noisy);
        logic [AW+5:0] e;
        int            lat;
        while (!result_valid && cyc < BASE_LAT + 200) begin
            trigger = noisy && (cyc == 500);
            @(posedge clk); #1; cyc++;
        end
        trigger = 1'b0;
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        chk("result_valid_seen", result_valid, 1);
        chk("best_lag", best_lag, e[AW+5:AW]);
        chk("min_sad", min_sad, e[AW-1:0]);
        chk("latency", cyc, lat);
        chk("busy_at_result", busy, 0);
        @(posedge clk); #1;
        chk("result_pulse_one_cycle", result_valid, 0);
    endtask

    task automatic run_test(input int mode, input bit gaps, input bit noisy,
                            input int lag, input int sad);
        int lat;
        fill(mode);
        lat = BASE_LAT + (gaps ? 9 * GAP_LEN : 0);
        if (mode == 5) model_push(lat);
        else begin
            exp_q.push_back({6'(lag), AW'(sad)});
            lat_q.push_back(lat);
        end
        drive_frame(gaps, noisy);
        wait_result(noisy);
    endtask

    // directed sequence
    initial begin
        reset_n = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
        left_data_in = '0; right_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_best_lag", best_lag, 0);
        chk("rst_min_sad", min_sad, 0);
        chk("rst_state", o_dbg_state, 0);
        reset_n = 1'b1;

        // sample_valid alone must not start anything
        sample_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        sample_valid = 1'b0;
        chk("idle_ignores_samples_state", o_dbg_state, 0);
        chk("idle_ignores_samples_busy", busy, 0);

        run_test(1, 0, 0, 30, 0);           // ramp
        run_test(3, 0, 0, 0, 0);            // constant, all-tie
        run_test(4, 0, 0, 0, 1966050);     // full-scale difference
        run_test(5, 0, 0, 0, 0);            // random, model-derived
        run_test(2, 0, 0, 35, 0);           // right delayed by 5

        // abort mid-sweep with an asynchronous reset
        fill(1);
        drive_frame(0, 0);
        repeat (20 * W + 5) begin @(posedge clk); #1; cyc++; end
        chk("sweep_busy", busy, 1);
        chk("sweep_state", o_dbg_state, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_best_lag", best_lag, 0);
        chk("abort_min_sad", min_sad, 0);
        chk("abort_result_valid", result_valid, 0);
        chk("abort_state", o_dbg_state, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_test(1, 0, 0, 30, 0);

        // stray triggers while busy plus sample gaps
        run_test(2, 1, 1, 35, 0);
        repeat (40) begin
            @(posedge clk); #1;
            if (result_valid) chk("no_second_result", result_valid, 0);
        end
        chk("no_requeue_busy", busy, 0);
        chk("no_requeue_state", o_dbg_state, 0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
